// File: rtl/serial_to_parallel_32_pkg.sv
// Shared types and constants for the 32-bit serial-to-parallel deserialiser.
package serial_to_parallel_32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_LOAD  = 2'd1,
    SR_SHL   = 2'd2,
    SR_SHR   = 2'd3
  } sr_op_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Bidirectional serial-in shift register; sr_next exposes the post-edge value
// so the owner can capture a word on the same edge that completes it.
module sipo_shift_reg
  import serial_to_parallel_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  sr_op_t           op,
  input  logic             load_dir,
  input  logic             s_bit,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] sr_next
);

  // The first bit lands at the end it will be shifted away from.
  always_comb begin
    sr_next = sr;
    case (op)
      SR_LOAD: begin
        if (load_dir == LSB_FIRST) sr_next = {s_bit, {(WIDTH-1){1'b0}}};
        else                       sr_next = {{(WIDTH-1){1'b0}}, s_bit};
      end
      SR_SHL:  sr_next = {sr[WIDTH-2:0], s_bit};
      SR_SHR:  sr_next = {s_bit, sr[WIDTH-1:1]};
      default: sr_next = sr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) sr <= '0;
    else       sr <= sr_next;
  end

endmodule

// File: rtl/serial_to_parallel_32.sv
// Serial-to-parallel deserialiser: receive FSM and bit counter feed a
// valid/ready holding register that flags overrun when a word is dropped.
module serial_to_parallel_32
  import serial_to_parallel_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             s_start,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  rx_state_t        state;
  logic             dir;
  sr_op_t           sr_op;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             start_bit;
  logic             shift_bit;
  logic             word_done;

  assign start_bit = s_valid && s_start;
  assign shift_bit = s_valid && !s_start && (state == SHIFT);
  assign word_done = shift_bit && (bit_cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == SHIFT);

  always_comb begin
    sr_op = SR_HOLD;
    if (start_bit)                    sr_op = SR_LOAD;
    else if (shift_bit && dir == LSB_FIRST) sr_op = SR_SHR;
    else if (shift_bit)               sr_op = SR_SHL;
  end

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk      (clk),
    .clear    (clear),
    .op       (sr_op),
    .load_dir (lsb_first),
    .s_bit    (s_bit),
    .sr       (sr),
    .sr_next  (sr_next)
  );

  // Receive FSM and bit counter; s_start restarts from any state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      dir     <= MSB_FIRST;
      bit_cnt <= '0;
    end else if (start_bit) begin
      state   <= SHIFT;
      dir     <= lsb_first;
      bit_cnt <= CNT_W'(1);
    end else if (word_done) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else if (shift_bit) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Holding register: a completed word loads only if the slot is empty or
  // being drained this edge; otherwise it is dropped and overrun sticks.
  always_ff @(posedge clk) begin
    if (clear) begin
      p_data  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (word_done) begin
      if (!p_valid || p_ready) begin
        p_data  <= sr_next;
        p_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: doc/serial_to_parallel_32.md
SERIAL_TO_PARALLEL_32 -- requirements
Module: serial_to_parallel_32

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the deserialised word width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 6, giving the bit-counter width (WIDTH must be at most 2^CNT_W - 1).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port s_start, input, 1 bit: frame start; qualified by s_valid, the accompanying bit is bit 0 of a new frame.
REQ-006 The module SHALL have port s_valid, input, 1 bit: serial bit strobe; s_bit is sampled when high.
REQ-007 The module SHALL have port s_bit, input, 1 bit: serial data.
REQ-008 The module SHALL have port lsb_first, input, 1 bit: 0 = MSB received first (shift left), 1 = LSB received first (shift right); sampled only with s_start.
REQ-009 The module SHALL have port p_data, output, WIDTH bits: the assembled word, held stable while p_valid is high.
REQ-010 The module SHALL have port p_valid, output, 1 bit: p_data is valid.
REQ-011 The module SHALL have port p_ready, input, 1 bit: consumer accepts p_data when p_valid is also high.
REQ-012 The module SHALL have port busy, output, 1 bit: a frame is being received.
REQ-013 The module SHALL have port bit_cnt, output, CNT_W bits: bits received in the current frame.
REQ-014 The module SHALL have port overrun, output, 1 bit: sticky flag, a completed word was dropped.

Function
REQ-015 Receive FSM states SHALL be IDLE and SHIFT; the output holding register with its p_valid flag SHALL be independent of the FSM.
REQ-016 In IDLE, s_valid with s_start low SHALL be ignored (the bit is dropped and bit_cnt stays 0).
REQ-017 s_valid with s_start high SHALL latch lsb_first, load the bit into the shift register, set bit_cnt to 1 and enter SHIFT, in any state.
REQ-018 In SHIFT, s_valid with s_start low SHALL shift s_bit in and increment bit_cnt.
- MSB-first: sr <= {sr[WIDTH-2:0], s_bit}.
- LSB-first: sr <= {s_bit, sr[WIDTH-1:1]}.
REQ-019 The edge that receives bit WIDTH SHALL copy the completed word to p_data, return the FSM to IDLE and clear bit_cnt to 0; p_valid SHALL be high on the following cycle (1-cycle latency from the last bit).
REQ-020 The handshake SHALL complete when p_valid and p_ready are both high; p_valid SHALL fall on the next edge unless a new word completes on that same edge.
REQ-021 If a word completes while p_valid is high and p_ready is low, the new word SHALL be dropped, p_data and p_valid SHALL be unchanged, and overrun SHALL be set.
REQ-022 If a word completes on the same edge as a handshake, the new word SHALL load, p_valid SHALL stay high, and overrun SHALL not change.
REQ-023 overrun SHALL clear only on clear.
REQ-024 busy SHALL be high exactly when the FSM is in SHIFT.
REQ-025 s_valid low SHALL freeze the shift register and bit_cnt; gaps between bits of any length are legal.
REQ-026 s_start in mid-frame SHALL abort the partial frame silently (no flag) and restart per REQ-017.

Reset
REQ-027 With clear high at a rising edge, the module SHALL set the FSM to IDLE, and p_data, the shift register, bit_cnt, p_valid, overrun, busy and the latched direction to 0; clear SHALL take priority over every other input.
REQ-028 A clear asserted mid-frame or while p_valid is high SHALL discard the partial frame and the held word without a handshake.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, SHIFT), the WIDTH and CNT_W defaults, and the direction encodings (MSB_FIRST=0, LSB_FIRST=1).
REQ-030 The bidirectional shift register SHALL be one sub-module, sipo_shift_reg (load-first-bit, shift-left, shift-right, hold), instantiated once; the FSM, counter and holding register SHALL stay in the top module.

Verification
REQ-031 The bench SHALL reset, then send s_start plus 32 bits MSB-first of 0xA5C3_0F81 with p_ready=1 -> p_data=0xA5C30F81, p_valid high exactly 1 cycle, overrun=0.
REQ-032 The bench SHALL send the same bit sequence with lsb_first=1 -> p_data equals its bit-reversal, 0x81F0C3A5.
REQ-033 The bench SHALL hold p_ready=0 and send two frames 0x11111111 then 0x22222222 -> p_data stays 0x11111111 and overrun=1; p_ready=1 -> p_valid falls, overrun stays 1.
REQ-034 The bench SHALL complete frame 0x33333333 on the same edge as the handshake of 0x11111111 -> p_valid stays high and p_data=0x33333333.
REQ-035 The bench SHALL send 10 bits, then s_start and a full frame 0xDEADBEEF with random s_valid gaps -> p_data=0xDEADBEEF, with no spurious p_valid after the aborted frame.
REQ-036 The bench SHALL assert clear after 20 bits -> on the next cycle busy=0 and bit_cnt=0 with no p_valid; the next full frame is received correctly.
